// File: rtl/multdiv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_sequencer_if
// Description : Issue/result bundle between the execute stage and the
//               iterative multiply/divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface multdiv_sequencer_if;
    logic        start;
    logic [5:0]  function_code;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output start, function_code, op_a, op_b,
        input  stall, busy, done, hi_out, lo_out
    );

    modport slave (
        input  start, function_code, op_a, op_b,
        output stall, busy, done, hi_out, lo_out
    );
endinterface
`default_nettype wire

// File: rtl/multdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_sequencer
// Description : 32-step shift-add multiply / restoring divide for MULT, MULTU,
//               DIV, DIVU with HI/LO result strobe. Define
//               MULTDIV_ZERO_SKIP_EN to bypass RUN on zero operands.
// Revision    : 1.0 - initial release
// ============================================================================
module multdiv_sequencer (
    input  wire logic          clk,
    input  wire logic          reset,
    multdiv_sequencer_if.slave bus
);

    localparam logic [1:0]  c_IDLE     = 2'd0;
    localparam logic [1:0]  c_RUN      = 2'd1;
    localparam logic [1:0]  c_DONE     = 2'd2;
    localparam logic [4:0]  c_LAST     = 5'd31;
    localparam logic [31:0] c_ALL_ONES = 32'hFFFF_FFFF;

    logic [1:0]  r_state;
    logic [4:0]  r_count;
    logic        r_is_div;
    logic        r_neg_main;
    logic        r_neg_rem;
    logic        r_div_zero;
    logic [31:0] r_a_raw;
    logic [31:0] r_operand;
    logic [63:0] r_acc;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // Operand decode, sampled only in IDLE
    logic        w_go;
    logic        w_signed;
    logic        w_is_div;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;

    assign w_go     = bus.start & (bus.function_code[5:2] == 4'b0110);
    assign w_signed = ~bus.function_code[0];
    assign w_is_div = bus.function_code[1];
    assign w_a_neg  = w_signed & bus.op_a[31];
    assign w_b_neg  = w_signed & bus.op_b[31];
    assign w_a_mag  = w_a_neg ? (32'd0 - bus.op_a) : bus.op_a;
    assign w_b_mag  = w_b_neg ? (32'd0 - bus.op_b) : bus.op_b;

`ifdef MULTDIV_ZERO_SKIP_EN
    logic w_zero_skip;
    assign w_zero_skip = w_is_div ? (bus.op_b == 32'd0)
                                  : ((bus.op_a == 32'd0) || (bus.op_b == 32'd0));
`endif

    // One iteration of either algorithm on the current accumulator
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [64:0] w_div_shift;
    logic [32:0] w_div_cand;
    logic        w_div_ge;
    logic [31:0] w_div_diff;
    logic [63:0] w_div_next;
    logic [63:0] w_acc_next;

    // w_mul_sum[32] is the add carry that lands in the top bit after the shift
    assign w_mul_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_operand} : 33'd0);
    assign w_mul_next  = {w_mul_sum, r_acc[31:1]};
    assign w_div_shift = {r_acc, 1'b0};
    assign w_div_cand  = w_div_shift[64:32];
    assign w_div_ge    = (w_div_cand >= {1'b0, r_operand});
    assign w_div_diff  = w_div_cand[31:0] - r_operand;
    assign w_div_next  = w_div_ge ? {w_div_diff, w_div_shift[31:1], 1'b1}
                                  : {w_div_cand[31:0], w_div_shift[31:0]};
    assign w_acc_next  = r_is_div ? w_div_next : w_mul_next;

    // Sign correction applied to the final step's accumulator
    logic [63:0] w_prod;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    always_comb begin
        w_prod   = r_neg_main ? (64'd0 - w_acc_next) : w_acc_next;
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
        if (r_is_div) begin
            if (r_div_zero) begin
                w_res_hi = r_a_raw;
                w_res_lo = c_ALL_ONES;
            end else begin
                w_res_hi = r_neg_rem  ? (32'd0 - w_acc_next[63:32]) : w_acc_next[63:32];
                w_res_lo = r_neg_main ? (32'd0 - w_acc_next[31:0])  : w_acc_next[31:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_count    <= 5'd0;
            r_is_div   <= 1'b0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_a_raw    <= 32'd0;
            r_operand  <= 32'd0;
            r_acc      <= 64'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_go) begin
                        r_count    <= 5'd0;
                        r_is_div   <= w_is_div;
                        r_neg_main <= w_a_neg ^ w_b_neg;
                        r_neg_rem  <= w_a_neg;
                        r_div_zero <= (bus.op_b == 32'd0);
                        r_a_raw    <= bus.op_a;
                        r_operand  <= w_is_div ? w_b_mag : w_a_mag;
                        r_acc      <= {32'd0, w_is_div ? w_a_mag : w_b_mag};
                        r_state    <= c_RUN;
                        r_busy     <= 1'b1;
`ifdef MULTDIV_ZERO_SKIP_EN
                        if (w_zero_skip) begin
                            r_state <= c_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_hi    <= w_is_div ? bus.op_a : 32'd0;
                            r_lo    <= w_is_div ? c_ALL_ONES : 32'd0;
                        end
`endif
                    end
                end
                c_RUN: begin
                    r_acc   <= w_acc_next;
                    r_count <= r_count + 5'd1;
                    if (r_count == c_LAST) begin
                        r_state <= c_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_hi    <= w_res_hi;
                        r_lo    <= w_res_lo;
                    end
                end
                c_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stall  = ((r_state == c_IDLE) & bus.start & ~reset) | (r_state == c_RUN);
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.hi_out = r_hi;
    assign bus.lo_out = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multdiv_sequencer
// Description : Randomized and directed bench for multdiv_sequencer against
//               an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multdiv_sequencer;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_checks;

    multdiv_sequencer_if bus ();

    multdiv_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // {hi, lo} from plain arithmetic on the architectural definition
    function automatic logic [63:0] ref_model(input logic [5:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        res = 64'd0;
        case (f)
            6'd24: begin
                sa  = longint'($signed(a));
                sb  = longint'($signed(b));
                res = 64'(sa * sb);
            end
            6'd25: res = 64'(a) * 64'(b);
            default: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else begin
                    if (f == 6'd26) begin
                        sa = longint'($signed(a));
                        sb = longint'($signed(b));
                    end else begin
                        sa = longint'({32'd0, a});
                        sb = longint'({32'd0, b});
                    end
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit toggle);
        logic [63:0] exp;
        int          exp_lat;
        int          lat;
        bit          skip;
        exp  = ref_model(f, a, b);
        skip = 1'b0;
`ifdef MULTDIV_ZERO_SKIP_EN
        skip = f[1] ? (b == 32'd0) : ((a == 32'd0) || (b == 32'd0));
`endif
        exp_lat = skip ? 1 : 33;
        @(negedge clk);
        bus.start         = 1'b1;
        bus.function_code = f;
        bus.op_a          = a;
        bus.op_b          = b;
        #1 check("stall_at_T", 64'(bus.stall), 64'd1);
        lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = k;
            end else begin
                check("stall_run", 64'(bus.stall), 64'd1);
                check("busy_run", 64'(bus.busy), 64'd1);
                if (toggle) begin
                    @(negedge clk);
                    bus.start = 1'($urandom);
                end
            end
        end
        check("done_latency", 64'(lat), 64'(exp_lat));
        if (lat != 0) begin
            check("stall_done", 64'(bus.stall), 64'd0);
            check("busy_done", 64'(bus.busy), 64'd0);
            check("hi", 64'(bus.hi_out), 64'(exp[63:32]));
            check("lo", 64'(bus.lo_out), 64'(exp[31:0]));
        end
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("done_one_cycle", 64'(bus.done), 64'd0);
        check("idle_busy", 64'(bus.busy), 64'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int pulses;
        n_pass            = 0;
        n_checks          = 0;
        reset             = 1'b1;
        bus.start         = 1'b0;
        bus.function_code = 6'd0;
        bus.op_a          = 32'd0;
        bus.op_b          = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", 64'(bus.stall), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hi", 64'(bus.hi_out), 64'd0);
        check("rst_lo", 64'(bus.lo_out), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(6'd24, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0);
        run_op(6'd26, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        run_op(6'd27, 32'h1234_5678, 32'h0000_0000, 1'b0);
        run_op(6'd26, 32'h1234_5678, 32'h0000_0000, 1'b0);
        run_op(6'd26, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op(6'd24, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0);

        for (int i = 0; i < 16; i++) begin
            run_op(6'(24 + $urandom_range(0, 3)), pick_operand(), pick_operand(),
                   1'($urandom_range(0, 1)));
        end

        // Abort an in-flight operation with reset at T+10
        @(negedge clk);
        bus.start         = 1'b1;
        bus.function_code = 6'd25;
        bus.op_a          = 32'h0001_2345;
        bus.op_b          = 32'h0006_789A;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_hi", 64'(bus.hi_out), 64'd0);
        check("abort_lo", 64'(bus.lo_out), 64'd0);
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) pulses++;
        end
        check("abort_no_done", 64'(pulses), 64'd0);

        run_op(6'd27, 32'd100, 32'd7, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
